rom_ctrl_rd_sched: RTL and testbench

- Read scheduler in front of the scrambled ROM datapath. It shares the single ROM read port between the ROM integrity checker and the bus host, and drives the physical and keystream address ports.
- Tracks outstanding reads in order. Returns scrambled data to the checker and cleartext data to the bus.
- After boot the checker releases the port and the bus gains exclusive access. Any later checker traffic raises a sticky alert.

---
 rtl/rom_ctrl_rd_sched.sv | 74 +++++++
 tb/tb_rom_ctrl_rd_sched.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/rom_ctrl_rd_sched.sv
// rom_ctrl_rd_sched: shares the ROM read port between integrity checker and bus, routing in-order responses by tag
module rom_ctrl_rd_sched #(
  parameter int Aw = 12,
  parameter int Width = 40,
  parameter int MaxOutstanding = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             chk_req_i,
  input  logic [Aw-1:0]    chk_addr_i,
  output logic             chk_gnt_o,
  output logic             chk_rvalid_o,
  output logic [Width-1:0] chk_rdata_o,
  input  logic             chk_done_i,
  input  logic             bus_req_i,
  input  logic [Aw-1:0]    bus_addr_i,
  output logic             bus_gnt_o,
  output logic             bus_rvalid_o,
  output logic [Width-1:0] bus_rdata_o,
  output logic             rom_req_o,
  output logic [Aw-1:0]    rom_addr_o,
  output logic [Aw-1:0]    prince_addr_o,
  input  logic             rom_rvalid_i,
  input  logic [Width-1:0] rom_scr_rdata_i,
  input  logic [Width-1:0] rom_clr_rdata_i,
  output logic             bus_mode_o,
  output logic             alert_o
);
  localparam int Pw = MaxOutstanding > 1 ? $clog2(MaxOutstanding) : 1;
  localparam int Cw = $clog2(MaxOutstanding + 1);
  typedef enum logic [1:0] {CHECK, DRAIN, BUS} state_e;
  state_e state, state_n;
  logic [MaxOutstanding-1:0] tags;
  logic [Pw-1:0] wptr, rptr;
  logic [Cw-1:0] cnt;
  logic empty, room, pop, push, head;
  always_comb begin
    empty = cnt == '0;
    pop = rom_rvalid_i & ~empty;
    room = (cnt != Cw'(MaxOutstanding)) | pop;
    head = tags[rptr];
    chk_gnt_o = (state == CHECK) & chk_req_i & room;
    bus_gnt_o = (state == BUS) & bus_req_i & room;
    push = chk_gnt_o | bus_gnt_o;
    rom_req_o = push;
    rom_addr_o = chk_gnt_o ? chk_addr_i : bus_gnt_o ? bus_addr_i : '0;
    prince_addr_o = chk_gnt_o ? chk_addr_i : bus_gnt_o ? bus_addr_i : '0;
    chk_rvalid_o = pop & ~head;
    bus_rvalid_o = pop & head;
    chk_rdata_o = chk_rvalid_o ? rom_scr_rdata_i : '0;
    bus_rdata_o = bus_rvalid_o ? rom_clr_rdata_i : '0;
    bus_mode_o = state == BUS;
    state_n = (state == CHECK) & chk_done_i ? DRAIN :
              (state == DRAIN) & empty & ~rom_rvalid_i ? BUS : state;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= CHECK;
      tags <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      alert_o <= 1'b0;
    end else begin
      state <= state_n;
      if (push) tags[wptr] <= bus_gnt_o;
      if (push) wptr <= wptr == Pw'(MaxOutstanding - 1) ? '0 : wptr + 1'b1;
      if (pop) rptr <= rptr == Pw'(MaxOutstanding - 1) ? '0 : rptr + 1'b1;
      cnt <= cnt + Cw'(push) - Cw'(pop);
      alert_o <= alert_o | (chk_req_i & (state == BUS)) | (chk_done_i & (state != CHECK)) |
                 (rom_rvalid_i & empty);
    end
  end
endmodule

// File: tb/tb_rom_ctrl_rd_sched.sv
// tb_rom_ctrl_rd_sched: directed and random checks of the read scheduler against a queue-based model
module tb_rom_ctrl_rd_sched;
  localparam int MAXO = 2;
  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic chk_req_i = 1'b0, chk_done_i = 1'b0, bus_req_i = 1'b0, rom_rvalid_i = 1'b0;
  logic [11:0] chk_addr_i = '0, bus_addr_i = '0;
  logic [39:0] rom_scr_rdata_i = '0, rom_clr_rdata_i = '0;
  logic chk_gnt_o, chk_rvalid_o, bus_gnt_o, bus_rvalid_o, rom_req_o, bus_mode_o, alert_o;
  logic [39:0] chk_rdata_o, bus_rdata_o;
  logic [11:0] rom_addr_o, prince_addr_o;
  int n_chk = 0;
  int n_fail = 0;
  int mode = 0;
  bit q[$];
  bit m_alert = 0;
  logic s_cg, s_bg, s_crv, s_brv, s_rq, s_mode, s_alert;
  logic [11:0] s_ra, s_pa;
  logic [39:0] s_cd, s_bd;
  always #5 clk = ~clk;
  rom_ctrl_rd_sched #(.Aw(12), .Width(40), .MaxOutstanding(MAXO)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .chk_req_i(chk_req_i), .chk_addr_i(chk_addr_i), .chk_gnt_o(chk_gnt_o),
    .chk_rvalid_o(chk_rvalid_o), .chk_rdata_o(chk_rdata_o), .chk_done_i(chk_done_i),
    .bus_req_i(bus_req_i), .bus_addr_i(bus_addr_i), .bus_gnt_o(bus_gnt_o),
    .bus_rvalid_o(bus_rvalid_o), .bus_rdata_o(bus_rdata_o),
    .rom_req_o(rom_req_o), .rom_addr_o(rom_addr_o), .prince_addr_o(prince_addr_o),
    .rom_rvalid_i(rom_rvalid_i), .rom_scr_rdata_i(rom_scr_rdata_i), .rom_clr_rdata_i(rom_clr_rdata_i),
    .bus_mode_o(bus_mode_o), .alert_o(alert_o)
  );
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic do_reset();
    rst_i = 1'b1;
    chk_req_i = 0; chk_done_i = 0; bus_req_i = 0; rom_rvalid_i = 0;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    mode = 0;
    q.delete();
    m_alert = 0;
  endtask
  task automatic cyc(bit cr, logic [11:0] ca, bit cd, bit br, logic [11:0] ba, bit rv,
                     logic [39:0] scr, logic [39:0] clr);
    int n;
    bit pop_e, head, room, ecg, ebg;
    logic [11:0] ea;
    chk_req_i = cr; chk_addr_i = ca; chk_done_i = cd;
    bus_req_i = br; bus_addr_i = ba;
    rom_rvalid_i = rv; rom_scr_rdata_i = scr; rom_clr_rdata_i = clr;
    @(negedge clk);
    n = q.size();
    pop_e = rv && n > 0;
    head = n > 0 ? q[0] : 1'b0;
    room = n < MAXO || pop_e;
    ecg = mode == 0 && cr && room;
    ebg = mode == 2 && br && room;
    ea = ecg ? ca : ebg ? ba : 12'h000;
    check("chk_gnt", 64'(chk_gnt_o), 64'(ecg));
    check("bus_gnt", 64'(bus_gnt_o), 64'(ebg));
    check("rom_req", 64'(rom_req_o), 64'(ecg || ebg));
    check("rom_addr", 64'(rom_addr_o), 64'(ea));
    check("prince_addr", 64'(prince_addr_o), 64'(ea));
    check("chk_rvalid", 64'(chk_rvalid_o), 64'(pop_e && !head));
    check("chk_rdata", 64'(chk_rdata_o), 64'((pop_e && !head) ? scr : 40'h0));
    check("bus_rvalid", 64'(bus_rvalid_o), 64'(pop_e && head));
    check("bus_rdata", 64'(bus_rdata_o), 64'((pop_e && head) ? clr : 40'h0));
    check("bus_mode", 64'(bus_mode_o), 64'(mode == 2));
    check("alert", 64'(alert_o), 64'(m_alert));
    s_cg = chk_gnt_o; s_bg = bus_gnt_o; s_crv = chk_rvalid_o; s_brv = bus_rvalid_o;
    s_rq = rom_req_o; s_mode = bus_mode_o; s_alert = alert_o;
    s_ra = rom_addr_o; s_pa = prince_addr_o; s_cd = chk_rdata_o; s_bd = bus_rdata_o;
    m_alert = m_alert || (cr && mode == 2) || (cd && mode != 0) || (rv && n == 0);
    if (pop_e) void'(q.pop_front());
    if (ecg || ebg) q.push_back(ebg);
    mode = (mode == 0 && cd) ? 1 : (mode == 1 && n == 0 && !rv) ? 2 : mode;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    cyc(0, 12'h0, 0, 0, 12'h0, 0, 40'h0, 40'h0);
  endtask
  initial begin
    do_reset();
    idle();
    check("reset_rom_req", 64'(s_rq), 64'(0));
    check("reset_alert", 64'(s_alert), 64'(0));
    cyc(1, 12'h000, 0, 0, 12'h0, 0, 40'h0, 40'h0);
    check("tp1_gnt0", 64'(s_cg), 64'(1));
    check("tp1_addr0", 64'({s_ra, s_pa}), 64'(24'h000000));
    cyc(1, 12'h001, 0, 0, 12'h0, 1, 40'h11_2233_4455, 40'h99_8877_6655);
    check("tp1_addr1", 64'({s_ra, s_pa}), 64'(24'h001001));
    check("tp1_rdata0", 64'(s_cd), 64'(40'h11_2233_4455));
    cyc(0, 12'h0, 0, 0, 12'h0, 1, 40'hAA_BBCC_DDEE, 40'h01_0203_0405);
    check("tp1_rvalid1", 64'({s_rq, s_crv, s_brv}), 64'(3'b010));
    check("tp1_rdata1", 64'(s_cd), 64'(40'hAA_BBCC_DDEE));
    cyc(1, 12'h002, 0, 1, 12'h123, 0, 40'h0, 40'h0);
    cyc(1, 12'h003, 0, 1, 12'h123, 0, 40'h0, 40'h0);
    cyc(1, 12'h004, 0, 1, 12'h123, 0, 40'h0, 40'h0);
    check("tp2_full_nogrant", 64'({s_cg, s_bg}), 64'(2'b00));
    cyc(1, 12'h004, 0, 1, 12'h123, 1, 40'h5, 40'h6);
    check("tp2_full_pop_grant", 64'(s_cg), 64'(1));
    cyc(0, 12'h0, 1, 1, 12'h123, 0, 40'h0, 40'h0);
    cyc(0, 12'h0, 0, 1, 12'h123, 1, 40'h7, 40'h8);
    check("tp3_drain_no_gnt", 64'({s_bg, s_mode}), 64'(2'b00));
    cyc(0, 12'h0, 0, 1, 12'h123, 1, 40'h9, 40'hA);
    check("tp3_drain_still", 64'(s_mode), 64'(0));
    cyc(0, 12'h0, 0, 1, 12'h123, 0, 40'h0, 40'h0);
    check("tp3_drain_empty", 64'({s_bg, s_mode}), 64'(2'b00));
    cyc(0, 12'h0, 0, 1, 12'h123, 0, 40'h0, 40'h0);
    check("tp3_bus_mode", 64'(s_mode), 64'(1));
    check("tp3_bus_gnt_addr", 64'({s_bg, s_ra}), 64'({1'b1, 12'h123}));
    cyc(0, 12'h0, 0, 0, 12'h0, 1, 40'hFF_FFFF_FFFF, 40'h00_DEAD_BEEF);
    check("tp4_bus_rvalid", 64'({s_brv, s_crv}), 64'(2'b10));
    check("tp4_bus_rdata", 64'(s_bd), 64'(40'h00_DEAD_BEEF));
    cyc(1, 12'h055, 0, 0, 12'h0, 0, 40'h0, 40'h0);
    check("tp5_chk_blocked", 64'({s_cg, s_alert}), 64'(2'b00));
    idle();
    check("tp5_alert_set", 64'(s_alert), 64'(1));
    repeat (3) idle();
    check("tp5_alert_sticky", 64'(s_alert), 64'(1));
    do_reset();
    cyc(0, 12'h0, 0, 0, 12'h0, 1, 40'h3, 40'h4);
    check("tp6_drop_rvalid", 64'({s_crv, s_brv}), 64'(2'b00));
    idle();
    check("tp6_empty_alert", 64'(s_alert), 64'(1));
    do_reset();
    cyc(1, 12'h0AB, 0, 0, 12'h0, 0, 40'h0, 40'h0);
    cyc(0, 12'h0, 1, 0, 12'h0, 0, 40'h0, 40'h0);
    idle();
    do_reset();
    idle();
    check("tp6_reset_drain", 64'({s_mode, s_alert, s_rq, s_crv, s_brv}), 64'(5'b00000));
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < 60; c++) begin
        bit cr, cd, br, rv;
        cr = (mode == 2) ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 2) != 0);
        cd = (mode == 0) ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 59) == 0);
        br = $urandom_range(0, 1) == 1;
        rv = (q.size() > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 29) == 0);
        cyc(cr, 12'($urandom), cd, br, 12'($urandom), rv, {8'($urandom), 32'($urandom)},
            {8'($urandom), 32'($urandom)});
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
